// File: rtl/expu_pkg.sv
// Shared widths, constants and result type for the Schraudolph bfloat16 exp unit.
package expu_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 7;
  localparam int unsigned BIAS   = 127;
  localparam int unsigned INT_W  = 9;
  localparam int unsigned FIX_W  = INT_W + MANT_W;

  // floor(log2(e) * 2^31); narrower constants are right shifts of this value
  localparam logic [31:0] LOG2E_Q31 = 32'hB8AA3B29;

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } bf16_mag_t;

  localparam bf16_mag_t RES_ZERO = '{exp: '0, mant: '0};
  localparam bf16_mag_t RES_INF  = '{exp: '1, mant: '0};
  localparam bf16_mag_t RES_NAN  = '{exp: '1, mant: 7'h40};

  function automatic logic [31:0] log2e_const(input int unsigned frac);
    return LOG2E_Q31 >> (31 - frac);
  endfunction

endpackage

// File: rtl/expu_log2e_mult.sv
// Combinational S*log2(e) multiply and exponent-driven shift to a Q9.7 magnitude.
module expu_log2e_mult
  import expu_pkg::*;
#(
  parameter int unsigned A_FRACTION = 14
) (
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [MANT_W-1:0] i_mant,
  output logic [FIX_W-1:0]  o_mag,
  output logic              o_sat
);

  localparam int unsigned    A_W     = A_FRACTION + 1;
  localparam int unsigned    P_W     = MANT_W + 1 + A_W;
  localparam logic [A_W-1:0] A_CONST = A_W'(log2e_const(A_FRACTION));

  logic [MANT_W:0] w_sig;
  logic [P_W-1:0]  w_prod;
  logic [9:0]      w_shift;

  assign w_sig   = {1'b1, i_mant};
  assign w_prod  = P_W'(w_sig) * P_W'(A_CONST);
  // Right shift of A_FRACTION - k; very small exponents shift every bit out
  assign w_shift = 10'(A_FRACTION + BIAS) - 10'(i_exp);

  assign o_sat = (i_exp >= EXP_W'(BIAS + INT_W - 1));
  assign o_mag = (i_exp == '0) ? '0 : FIX_W'(w_prod >> w_shift);

endmodule

// File: rtl/expu_schraudolph.sv
// bfloat16 e^x via Schraudolph's 2^I*(1+F) trick, one-cycle registered output.
// Optional EXPU_SCHRAUDOLPH_NAN_EN decodes NaN inputs to a quiet NaN result.
module expu_schraudolph
  import expu_pkg::*;
#(
  parameter int unsigned A_FRACTION = 14
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [15:0] float_i,
  output logic        valid_o,
  output logic [7:0]  exponent_o,
  output logic [6:0]  mantissa_o
);

  logic                     w_sign;
  logic [EXP_W-1:0]         w_exp;
  logic [MANT_W-1:0]        w_mant;
  logic [FIX_W-1:0]         w_mag;
  logic                     w_sat;
  logic signed [FIX_W:0]    w_z;
  logic signed [9:0]        w_int;
  logic signed [9:0]        w_biased;
  bf16_mag_t                w_res;

  logic                     r_valid;
  bf16_mag_t                r_res;

  assign {w_sign, w_exp, w_mant} = float_i;

  expu_log2e_mult #(.A_FRACTION(A_FRACTION)) u_mult (
    .i_exp  (w_exp),
    .i_mant (w_mant),
    .o_mag  (w_mag),
    .o_sat  (w_sat)
  );

  assign w_z      = w_sign ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
  // Upper bits of the two's-complement value are the floored integer part
  assign w_int    = w_z[FIX_W:MANT_W];
  assign w_biased = w_int + $signed(10'(BIAS));

  always_comb begin
    w_res = '{exp: w_biased[EXP_W-1:0], mant: w_z[MANT_W-1:0]};
    if (w_sat) begin
      w_res = w_sign ? RES_ZERO : RES_INF;
    end else if (w_biased <= 10'sd0) begin
      w_res = RES_ZERO;
    end else if (w_biased >= 10'sd255) begin
      w_res = RES_INF;
    end
`ifdef EXPU_SCHRAUDOLPH_NAN_EN
    if ((w_exp == '1) && (w_mant != '0)) begin
      w_res = RES_NAN;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_res   <= RES_ZERO;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_res <= w_res;
      end
    end
  end

  assign valid_o    = r_valid;
  assign exponent_o = r_res.exp;
  assign mantissa_o = r_res.mant;

endmodule

// File: tb/tb_expu_schraudolph.sv
// Self-checking bench for expu_schraudolph against an arithmetic reference of e^x.
module tb_expu_schraudolph;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [15:0] float_i = '0;
  logic        valid_o;
  logic [7:0]  exponent_o;
  logic [6:0]  mantissa_o;

  int n_checks = 0;
  int n_errors = 0;

  localparam longint A_VAL = 23637;

  expu_schraudolph #(.A_FRACTION(14)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .float_i    (float_i),
    .valid_o    (valid_o),
    .exponent_o (exponent_o),
    .mantissa_o (mantissa_o)
  );

  always #5 clk_i = ~clk_i;

  // x*log2(e) in units of 2^-7, floored, then split into 2^I * (1 + F/128)
  function automatic logic [14:0] model(input logic [15:0] f);
    longint s, e, m, k, mag, z, ip, fr, eb;
    s = longint'(f[15]);
    e = longint'(f[14:7]);
    m = longint'(f[6:0]);
`ifdef EXPU_SCHRAUDOLPH_NAN_EN
    if (e == 255 && m != 0) return {8'hFF, 7'h40};
`endif
    if (e == 0) begin
      mag = 0;
    end else begin
      k = e - 127;
      if (k >= 8) return (s != 0) ? 15'h0000 : {8'hFF, 7'h00};
      if (14 - k >= 40) mag = 0;
      else mag = ((128 + m) * A_VAL) / (longint'(1) << (14 - k));
    end
    z  = (s != 0) ? -mag : mag;
    ip = (z >= 0) ? (z / 128) : -((-z + 127) / 128);
    fr = z - ip * 128;
    eb = ip + 127;
    if (eb <= 0)   return 15'h0000;
    if (eb >= 255) return {8'hFF, 7'h00};
    return {eb[7:0], fr[6:0]};
  endfunction

  task automatic step(input logic v, input logic [15:0] f);
    valid_i = v;
    float_i = f;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
    n_checks++;
    if ({exponent_o, mantissa_o} !== 15'h0) begin
      n_errors++; $display("FAIL reset_result got %h/%h want 00/00", exponent_o, mantissa_o);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] vin  [11];
    logic [7:0]  vexp [11];
    logic [6:0]  vman [11];
    logic [6:0]  nan_man;
`ifdef EXPU_SCHRAUDOLPH_NAN_EN
    nan_man = 7'h40;
`else
    nan_man = 7'h00;
`endif
    vin  = '{16'hBF80, 16'h3F80, 16'h0000, 16'hC000, 16'hC300, 16'h42C8,
             16'h42B0, 16'hFF80, 16'h7F80, 16'h7FC0, 16'h8000};
    vexp = '{8'h7D, 8'h80, 8'h7F, 8'h7C, 8'h00, 8'hFF, 8'hFD, 8'h00, 8'hFF, 8'hFF, 8'h7F};
    vman = '{7'h48, 7'h38, 7'h00, 7'h0F, 7'h00, 7'h00, 7'h7A, 7'h00, 7'h00, nan_man, 7'h00};
    for (int i = 0; i < 11; i++) begin
      step(1'b1, vin[i]);
      n_checks++;
      if ({valid_o, exponent_o, mantissa_o} !== {1'b1, vexp[i], vman[i]}) begin
        n_errors++;
        $display("FAIL directed_%h got v=%b %h/%h want v=1 %h/%h",
                 vin[i], valid_o, exponent_o, mantissa_o, vexp[i], vman[i]);
      end
    end
  endtask

  task automatic test_monotonic();
    logic [14:0] prev = 15'h7FFF;
    logic [14:0] got;
    logic [15:0] f;
    for (int e = 127; e <= 131; e++) begin
      for (int m = 0; m < 128; m++) begin
        f = {1'b1, 8'(e), 7'(m)};
        step(1'b1, f);
        got = {exponent_o, mantissa_o};
        n_checks++;
        if (got !== model(f)) begin
          n_errors++; $display("FAIL sweep_model %h got %h want %h", f, got, model(f));
        end
        n_checks++;
        if (got > prev || got > 15'h3F80) begin
          n_errors++; $display("FAIL sweep_monotonic %h got %h prev %h limit 3f80", f, got, prev);
        end
        prev = got;
      end
    end
  endtask

  task automatic test_stream();
    logic [14:0] exp_res = {exponent_o, mantissa_o};
    logic        v;
    logic [15:0] f;
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 2) != 0);
      f = 16'($urandom);
      if ($urandom_range(0, 1) == 1) f[14:7] = 8'($urandom_range(115, 140));
      step(v, f);
      if (v) exp_res = model(f);
      n_checks++;
      if ({valid_o, exponent_o, mantissa_o} !== {v, exp_res}) begin
        n_errors++;
        $display("FAIL stream_%0d in=%h v=%b got v=%b %h want v=%b %h",
                 i, f, v, valid_o, {exponent_o, mantissa_o}, v, exp_res);
      end
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b1, 16'h3F80);
    n_checks++;
    if ({valid_o, exponent_o, mantissa_o} !== {1'b1, 8'h80, 7'h38}) begin
      n_errors++; $display("FAIL pre_reset got v=%b %h/%h want v=1 80/38", valid_o, exponent_o, mantissa_o);
    end
    valid_i = 1'b1;
    float_i = 16'hBF80;
    #2;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if ({valid_o, exponent_o, mantissa_o} !== 16'h0) begin
      n_errors++; $display("FAIL async_reset got v=%b %h/%h want v=0 00/00", valid_o, exponent_o, mantissa_o);
    end
    @(posedge clk_i);
    #1;
    n_checks++;
    if ({valid_o, exponent_o, mantissa_o} !== 16'h0) begin
      n_errors++; $display("FAIL reset_hold got v=%b %h/%h want v=0 00/00", valid_o, exponent_o, mantissa_o);
    end
    rst_i = 1'b0;
    step(1'b1, 16'hC000);
    n_checks++;
    if ({valid_o, exponent_o, mantissa_o} !== {1'b1, 8'h7C, 7'h0F}) begin
      n_errors++; $display("FAIL post_reset got v=%b %h/%h want v=1 7c/0f", valid_o, exponent_o, mantissa_o);
    end
    step(1'b0, 16'h42C8);
    n_checks++;
    if ({valid_o, exponent_o, mantissa_o} !== {1'b0, 8'h7C, 7'h0F}) begin
      n_errors++; $display("FAIL idle_hold got v=%b %h/%h want v=0 7c/0f", valid_o, exponent_o, mantissa_o);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_monotonic();
    test_stream();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
